// File: rtl/ltsm_sb_pkg.sv
// ltsm_sb_pkg: shared LTSM sideband state encodings, message codes and msg_info encodings
package ltsm_sb_pkg;
  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_WAIT_RX     = 3'd1;
  localparam logic [2:0] ST_SEND_REQ    = 3'd2;
  localparam logic [2:0] ST_WAIT_RESP   = 3'd3;
  localparam logic [2:0] ST_DONE        = 3'd4;
  localparam logic [2:0] ST_TIMEOUT_ERR = 3'd5;
  typedef enum logic [2:0] {
    IDLE        = ST_IDLE,
    WAIT_RX     = ST_WAIT_RX,
    SEND_REQ    = ST_SEND_REQ,
    WAIT_RESP   = ST_WAIT_RESP,
    DONE        = ST_DONE,
    TIMEOUT_ERR = ST_TIMEOUT_ERR
  } hs_state_t;
  localparam logic [3:0] PHYRETRAIN_START_REQ  = 4'd1;
  localparam logic [3:0] PHYRETRAIN_START_RESP = 4'd2;
  localparam logic [3:0] TRAINERROR_ENTRY_REQ  = 4'd3;
  localparam logic [3:0] TRAINERROR_ENTRY_RESP = 4'd4;
  localparam logic [3:0] LINKSPEED_EXIT_REQ    = 4'd5;
  localparam logic [3:0] LINKSPEED_EXIT_RESP   = 4'd6;
  localparam logic [2:0] INFO_TXSELFCAL = 3'b001;
  localparam logic [2:0] INFO_SPEEDIDLE = 3'b010;
  localparam logic [2:0] INFO_REPAIR    = 3'b100;
endpackage

// File: rtl/ltsm_hs_timer.sv
// ltsm_hs_timer: saturating cycle counter with clear/enable, expired at MAX_COUNT-1
module ltsm_hs_timer #(
  parameter int MAX_COUNT = 8000
)(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(MAX_COUNT);
  localparam logic [W-1:0] LAST = W'(MAX_COUNT - 1);
  logic [W-1:0] cnt;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) cnt <= '0;
    else cnt <= clr ? '0 : (en && cnt != LAST) ? cnt + W'(1) : cnt;
  assign expired = cnt == LAST;
endmodule

// File: rtl/ltsm_sb_handshake_tx.sv
// ltsm_sb_handshake_tx: TX sideband request/response handshake with timeout; define LTSM_SB_HS_RETRY_EN for bounded retries
module ltsm_sb_handshake_tx
  import ltsm_sb_pkg::*;
#(
  parameter int SB_MSG_WIDTH   = 4,
  parameter int INFO_WIDTH     = 3,
  parameter int TIMEOUT_CYCLES = 8000,
  parameter int MAX_RETRIES    = 3
)(
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_en,
  input  logic [SB_MSG_WIDTH-1:0]            i_req_code,
  input  logic [SB_MSG_WIDTH-1:0]            i_resp_code,
  input  logic [INFO_WIDTH-1:0]              i_req_info,
  input  logic                               i_falling_edge_busy,
  input  logic                               i_rx_valid,
  input  logic [SB_MSG_WIDTH-1:0]            i_decoded_SB_msg,
  input  logic                               i_rx_msg_valid,
  output logic [SB_MSG_WIDTH-1:0]            o_encoded_SB_msg_tx,
  output logic [INFO_WIDTH-1:0]              o_msg_info,
  output logic                               o_valid_tx,
  output logic                               o_done,
  output logic                               o_timeout,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   o_retry_cnt
);
  localparam int RW = $clog2(MAX_RETRIES + 1);
`ifdef LTSM_SB_HS_RETRY_EN
  localparam logic [RW-1:0] MAXR = RW'(MAX_RETRIES);
`endif
  hs_state_t state, nxt;
  logic [SB_MSG_WIDTH-1:0] req_code, resp_code, req_nxt, resp_nxt, msg_nxt;
  logic [INFO_WIDTH-1:0] info_nxt;
  logic [RW-1:0] retry_nxt;
  logic valid_nxt, done_nxt, to_nxt, expired, resp_hit;
  assign resp_hit = i_rx_msg_valid && i_decoded_SB_msg == resp_code;
  ltsm_hs_timer #(.MAX_COUNT(TIMEOUT_CYCLES)) u_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .clr     (!i_en || state == SEND_REQ),
    .en      (state == WAIT_RESP),
    .expired (expired)
  );
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state               <= IDLE;
      req_code            <= '0;
      resp_code           <= '0;
      o_encoded_SB_msg_tx <= '0;
      o_msg_info          <= '0;
      o_valid_tx          <= 1'b0;
      o_done              <= 1'b0;
      o_timeout           <= 1'b0;
      o_retry_cnt         <= '0;
    end else begin
      state               <= nxt;
      req_code            <= req_nxt;
      resp_code           <= resp_nxt;
      o_encoded_SB_msg_tx <= msg_nxt;
      o_msg_info          <= info_nxt;
      o_valid_tx          <= valid_nxt;
      o_done              <= done_nxt;
      o_timeout           <= to_nxt;
      o_retry_cnt         <= retry_nxt;
    end
  always_comb begin
    nxt       = state;
    req_nxt   = req_code;
    resp_nxt  = resp_code;
    msg_nxt   = o_encoded_SB_msg_tx;
    info_nxt  = o_msg_info;
    valid_nxt = o_valid_tx && !(i_falling_edge_busy && !i_rx_valid);
    done_nxt  = o_done;
    to_nxt    = o_timeout;
    retry_nxt = o_retry_cnt;
    if (!i_en) begin
      nxt       = IDLE;
      msg_nxt   = '0;
      info_nxt  = '0;
      valid_nxt = 1'b0;
      done_nxt  = 1'b0;
      to_nxt    = 1'b0;
      retry_nxt = '0;
    end else
      case (state)
        IDLE: begin
          req_nxt  = i_req_code;
          resp_nxt = i_resp_code;
          nxt      = (i_rx_msg_valid && i_decoded_SB_msg == i_req_code) ? WAIT_RX : SEND_REQ;
        end
        WAIT_RX: nxt = (i_falling_edge_busy && i_rx_valid) ? SEND_REQ : WAIT_RX;
        SEND_REQ: begin
          msg_nxt   = req_code;
          info_nxt  = i_req_info;
          valid_nxt = 1'b1;
          nxt       = WAIT_RESP;
        end
        WAIT_RESP:
          if (resp_hit) begin
            nxt      = DONE;
            done_nxt = 1'b1;
          end else if (expired) begin
`ifdef LTSM_SB_HS_RETRY_EN
            if (o_retry_cnt < MAXR) begin
              retry_nxt = o_retry_cnt + RW'(1);
              nxt       = SEND_REQ;
            end else begin
              nxt    = TIMEOUT_ERR;
              to_nxt = 1'b1;
            end
`else
            nxt    = TIMEOUT_ERR;
            to_nxt = 1'b1;
`endif
          end
        default: ;
      endcase
  end
endmodule

// File: tb/tb_ltsm_sb_handshake_tx.sv
// tb_ltsm_sb_handshake_tx: directed checks of handshake, collision, timeout/retry, abort and async reset
module tb_ltsm_sb_handshake_tx;
  localparam int SBW = 4, IW = 3, TO = 16, MR = 3, RW = $clog2(MR + 1);
  logic i_clk = 1'b0, i_rst_n = 1'b0, i_en = 1'b0;
  logic [SBW-1:0] i_req_code = '0, i_resp_code = '0, i_decoded_SB_msg = '0;
  logic [IW-1:0] i_req_info = '0;
  logic i_falling_edge_busy = 1'b0, i_rx_valid = 1'b0, i_rx_msg_valid = 1'b0;
  logic [SBW-1:0] o_encoded_SB_msg_tx;
  logic [IW-1:0] o_msg_info;
  logic o_valid_tx, o_done, o_timeout;
  logic [RW-1:0] o_retry_cnt;
  int total = 0, passed = 0;
  ltsm_sb_handshake_tx #(
    .SB_MSG_WIDTH(SBW), .INFO_WIDTH(IW), .TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en),
    .i_req_code(i_req_code), .i_resp_code(i_resp_code), .i_req_info(i_req_info),
    .i_falling_edge_busy(i_falling_edge_busy), .i_rx_valid(i_rx_valid),
    .i_decoded_SB_msg(i_decoded_SB_msg), .i_rx_msg_valid(i_rx_msg_valid),
    .o_encoded_SB_msg_tx(o_encoded_SB_msg_tx), .o_msg_info(o_msg_info),
    .o_valid_tx(o_valid_tx), .o_done(o_done), .o_timeout(o_timeout),
    .o_retry_cnt(o_retry_cnt)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask
  task automatic w15();
    i_falling_edge_busy = 1'b1;
    tick();
    i_falling_edge_busy = 1'b0;
    repeat (TO - 2) tick();
  endtask
  task automatic all_zero(input string tag);
    chk({tag, "_msg"}, o_encoded_SB_msg_tx, 0);
    chk({tag, "_info"}, o_msg_info, 0);
    chk({tag, "_valid"}, o_valid_tx, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_timeout"}, o_timeout, 0);
    chk({tag, "_retry"}, o_retry_cnt, 0);
  endtask
  task automatic start(input logic [SBW-1:0] rq, input logic [SBW-1:0] rs, input logic [IW-1:0] inf);
    i_req_code = rq;
    i_resp_code = rs;
    i_req_info = inf;
    i_en = 1'b1;
    tick();
  endtask
  task automatic stop();
    i_en = 1'b0;
    tick();
    tick();
  endtask
  initial begin
    tick();
    all_zero("reset");
    i_rst_n = 1'b1;
    tick();
    all_zero("post_reset");
    start(4'd1, 4'd2, 3'b001);
    chk("t1_valid_early", o_valid_tx, 0);
    tick();
    chk("t1_valid", o_valid_tx, 1);
    chk("t1_msg", o_encoded_SB_msg_tx, 1);
    chk("t1_info", o_msg_info, 3'b001);
    i_falling_edge_busy = 1'b1;
    tick();
    i_falling_edge_busy = 1'b0;
    chk("t1_valid_clr", o_valid_tx, 0);
    i_decoded_SB_msg = 4'd2;
    i_rx_msg_valid = 1'b1;
    tick();
    i_rx_msg_valid = 1'b0;
    chk("t1_done", o_done, 1);
    chk("t1_no_timeout", o_timeout, 0);
    repeat (3) tick();
    chk("t1_done_held", o_done, 1);
    i_en = 1'b0;
    tick();
    all_zero("t1_abort");
    tick();
    i_decoded_SB_msg = 4'd1;
    i_rx_msg_valid = 1'b1;
    start(4'd1, 4'd2, 3'b010);
    i_rx_msg_valid = 1'b0;
    repeat (3) tick();
    chk("t2_wait_rx", o_valid_tx, 0);
    i_falling_edge_busy = 1'b1;
    tick();
    i_falling_edge_busy = 1'b0;
    tick();
    tick();
    chk("t2_busy_no_rx", o_valid_tx, 0);
    i_falling_edge_busy = 1'b1;
    i_rx_valid = 1'b1;
    tick();
    i_falling_edge_busy = 1'b0;
    i_rx_valid = 1'b0;
    chk("t2_send_entry", o_valid_tx, 0);
    tick();
    chk("t2_valid", o_valid_tx, 1);
    chk("t2_msg", o_encoded_SB_msg_tx, 1);
    chk("t2_info", o_msg_info, 3'b010);
    i_decoded_SB_msg = 4'd2;
    i_rx_msg_valid = 1'b1;
    tick();
    i_rx_msg_valid = 1'b0;
    chk("t2_done", o_done, 1);
    stop();
    start(4'd1, 4'd2, 3'b010);
    tick();
    chk("t3_valid", o_valid_tx, 1);
`ifdef LTSM_SB_HS_RETRY_EN
    for (int r = 1; r <= MR; r++) begin
      w15();
      chk("t3_pre_retry", o_retry_cnt, r - 1);
      tick();
      chk("t3_retry_cnt", o_retry_cnt, r);
      chk("t3_no_timeout", o_timeout, 0);
      chk("t3_valid_low", o_valid_tx, 0);
      i_req_info = IW'(r + 3);
      tick();
      chk("t3_resend_valid", o_valid_tx, 1);
      chk("t3_resend_info", o_msg_info, r + 3);
    end
    w15();
    chk("t3_pre_timeout", o_timeout, 0);
    tick();
    chk("t3_timeout", o_timeout, 1);
    chk("t3_retry_final", o_retry_cnt, MR);
`else
    w15();
    chk("t3_pre_timeout", o_timeout, 0);
    tick();
    chk("t3_timeout", o_timeout, 1);
    chk("t3_retry_zero", o_retry_cnt, 0);
    repeat (3) tick();
    chk("t3_no_resend", o_valid_tx, 0);
    chk("t3_timeout_held", o_timeout, 1);
`endif
    i_en = 1'b0;
    tick();
    all_zero("t3_abort");
    tick();
    start(4'd1, 4'd2, 3'b100);
    tick();
    w15();
    i_decoded_SB_msg = 4'd2;
    i_rx_msg_valid = 1'b1;
    tick();
    i_rx_msg_valid = 1'b0;
    chk("t4_done", o_done, 1);
    chk("t4_timeout", o_timeout, 0);
    chk("t4_retry", o_retry_cnt, 0);
    stop();
    start(4'd1, 4'd2, 3'b111);
    tick();
    repeat (5) tick();
    chk("t5_valid_mid", o_valid_tx, 1);
    i_en = 1'b0;
    tick();
    all_zero("t5_abort");
    tick();
    start(4'd3, 4'd4, 3'b100);
    tick();
    chk("t5_valid", o_valid_tx, 1);
    chk("t5_msg", o_encoded_SB_msg_tx, 3);
    chk("t5_info", o_msg_info, 3'b100);
    w15();
    chk("t5_timer_fresh", o_timeout, 0);
    chk("t5_retry_fresh", o_retry_cnt, 0);
    tick();
`ifdef LTSM_SB_HS_RETRY_EN
    chk("t5_expire", o_retry_cnt, 1);
`else
    chk("t5_expire", o_timeout, 1);
`endif
    stop();
    start(4'd1, 4'd2, 3'b001);
    #2;
    i_rst_n = 1'b0;
    #2;
    all_zero("t6_async");
    tick();
    i_en = 1'b0;
    tick();
    i_rst_n = 1'b1;
    tick();
    all_zero("t6_idle");
    start(4'd1, 4'd2, 3'b001);
    chk("t6_restart_early", o_valid_tx, 0);
    tick();
    chk("t6_restart_valid", o_valid_tx, 1);
    i_decoded_SB_msg = 4'd3;
    i_rx_msg_valid = 1'b1;
    w15();
    chk("t6_wrong_resp_done", o_done, 0);
    chk("t6_wrong_resp_to", o_timeout, 0);
    i_decoded_SB_msg = 4'd1;
    tick();
    i_rx_msg_valid = 1'b0;
    chk("t6_ignored_done", o_done, 0);
`ifdef LTSM_SB_HS_RETRY_EN
    chk("t6_timer_ran", o_retry_cnt, 1);
`else
    chk("t6_timer_ran", o_timeout, 1);
`endif
    stop();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
